// File: rtl/crc_seq_pkg.sv
// Shared types and constants for the CRC-32 sequencer.
// Also holds the reflected table generator used to build the byte-step lookup ROM.
package crc_seq_pkg;

    localparam int CRC_W  = 32;
    localparam int BYTE_W = 8;
    localparam logic [CRC_W-1:0] CRC_POLY = 32'hEDB88320;

    typedef enum logic [1:0] {
        OP_INIT   = 2'd0,
        OP_UPDATE = 2'd1,
        OP_FINAL  = 2'd2,
        OP_READ   = 2'd3
    } crc_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } crc_state_t;

    // One entry of the reflected CRC-32 table; only ever evaluated on constants.
    function automatic logic [CRC_W-1:0] crc_table_entry(input logic [BYTE_W-1:0] idx);
        logic [CRC_W-1:0] c;
        c = {{(CRC_W-BYTE_W){1'b0}}, idx};
        for (int b = 0; b < BYTE_W; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_byte_lut.sv
// Combinational single-byte CRC-32 step: crc_out = rom[crc_in[7:0]^data_in] ^ (crc_in >> 8).
// The 256x32 table is the image that ROM_FILE names, elaborated here from the polynomial.
module crc_byte_lut
    import crc_seq_pkg::*;
#(
    parameter string ROM_FILE = "crc_rom.hex"
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [BYTE_W-1:0] data_in,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0]  rom [256];
    logic [BYTE_W-1:0] index;

    for (genvar i = 0; i < 256; i++) begin : g_rom
        assign rom[i] = crc_table_entry(BYTE_W'(i));
    end

    assign index   = crc_in[BYTE_W-1:0] ^ data_in;
    assign crc_out = rom[index] ^ (crc_in >> BYTE_W);

endmodule

// File: rtl/crc_sequencer.sv
// Multi-byte CRC-32 sequencer: accepts a word and byte count, steps one byte per cycle
// LSB first, and keeps the running CRC across requests for streaming long buffers.
module crc_sequencer
    import crc_seq_pkg::*;
#(
    parameter logic [CRC_W-1:0] INIT_VALUE = 32'hFFFFFFFF,
    parameter logic [CRC_W-1:0] FINAL_XOR  = 32'hFFFFFFFF,
    parameter string            ROM_FILE   = "crc_rom.hex"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [CRC_W-1:0] req_data,
    input  logic [1:0]       req_len,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [CRC_W-1:0] rsp_data,
    output logic             busy
);

    crc_state_t       state;
    logic [CRC_W-1:0] crc_reg;
    logic [CRC_W-1:0] shift;
    logic [1:0]       count;
    logic [CRC_W-1:0] lut_out;

    crc_byte_lut #(
        .ROM_FILE (ROM_FILE)
    ) u_lut (
        .crc_in  (crc_reg),
        .data_in (shift[BYTE_W-1:0]),
        .crc_out (lut_out)
    );

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // FINAL leaves crc_reg untouched so a later UPDATE continues the same stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            crc_reg   <= INIT_VALUE;
            shift     <= '0;
            count     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        case (crc_op_t'(req_op))
                            OP_INIT: begin
                                crc_reg   <= req_data;
                                rsp_data  <= req_data;
                                rsp_valid <= 1'b1;
                                state     <= RESP;
                            end
                            OP_READ: begin
                                rsp_data  <= crc_reg;
                                rsp_valid <= 1'b1;
                                state     <= RESP;
                            end
                            OP_FINAL: begin
                                rsp_data  <= crc_reg ^ FINAL_XOR;
                                rsp_valid <= 1'b1;
                                state     <= RESP;
                            end
                            default: begin
                                shift <= req_data;
                                count <= req_len;
                                state <= BUSY;
                            end
                        endcase
                    end
                end
                BUSY: begin
                    crc_reg <= lut_out;
                    shift   <= shift >> BYTE_W;
                    if (count == 2'd0) begin
                        rsp_data  <= lut_out;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        count <= count - 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_sequencer.sv
// Self-checking bench for crc_sequencer: directed vectors plus random ops against a
// bit-serial CRC-32 reference model.
module tb_crc_sequencer;

    localparam logic [31:0] POLY = 32'hEDB88320;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic [1:0]  req_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;

    int          n_checks;
    int          n_pass;
    logic [31:0] ref_crc;
    logic [31:0] got;

    crc_sequencer #(
        .INIT_VALUE (32'hFFFFFFFF),
        .FINAL_XOR  (32'hFFFFFFFF),
        .ROM_FILE   ("crc_rom.hex")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: standard reflected CRC-32 computed one bit at a time over n bytes.
    function automatic logic [31:0] ref_update(input logic [31:0] c, input logic [31:0] d, input int n);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < n; i++) begin
            r = r ^ {24'h0, d[8*i +: 8]};
            for (int b = 0; b < 8; b++) begin
                r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
            end
        end
        return r;
    endfunction

    // One full transaction: accept, latency check, optional backpressure, handshake.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] data, input logic [1:0] len,
                                 input int hold, output logic [31:0] rsp);
        int          k;
        int          lat;
        logic [31:0] first;
        lat       = (op == 2'd1) ? int'(len) + 1 : 0;
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        req_len   = len;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_data  = $urandom;
        k = 0;
        while (!rsp_valid && k < 10) begin
            checkOutput("busy_flag", {31'h0, busy}, 32'h1);
            @(posedge clk); #1;
            k++;
        end
        checkOutput("latency", 32'(k), 32'(lat));
        first = rsp_data;
        rsp   = rsp_data;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            req_op    = 2'd0;
            req_data  = $urandom;
            @(posedge clk); #1;
            checkOutput("stall_valid", {31'h0, rsp_valid}, 32'h1);
            checkOutput("stall_data", rsp_data, first);
            checkOutput("stall_ready", {31'h0, req_ready}, 32'h0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checkOutput("post_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("post_ready", {31'h0, req_ready}, 32'h1);
    endtask

    task automatic runOp(input logic [1:0] op, input logic [31:0] data, input logic [1:0] len,
                         input int hold, output logic [31:0] rsp);
        logic [31:0] exp;
        case (op)
            2'd0: begin ref_crc = data; exp = data; end
            2'd1: begin ref_crc = ref_update(ref_crc, data, int'(len) + 1); exp = ref_crc; end
            2'd2: exp = ref_crc ^ 32'hFFFFFFFF;
            default: exp = ref_crc;
        endcase
        applyStimulus(op, data, len, hold, rsp);
        checkOutput("rsp_data", rsp, exp);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        ref_crc   = 32'hFFFFFFFF;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_data  = '0;
        req_len   = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("reset_rsp_data", rsp_data, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_req_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        runOp(2'd3, 32'h0, 2'd0, 0, got);
        checkOutput("reset_read", got, 32'hFFFFFFFF);

        // Single byte and byte-ignore vectors.
        runOp(2'd0, 32'hFFFFFFFF, 2'd0, 0, got);
        runOp(2'd1, 32'h00000000, 2'd0, 0, got);
        checkOutput("single_byte", got, 32'h2DFD1072);
        runOp(2'd2, 32'h0, 2'd0, 0, got);
        checkOutput("single_final", got, 32'hD202EF8D);
        runOp(2'd0, 32'hFFFFFFFF, 2'd0, 0, got);
        runOp(2'd1, 32'hDEADBE00, 2'd0, 1, got);
        checkOutput("byte_ignore", got, 32'h2DFD1072);

        // "123456789" check string, then non-destructive FINAL.
        runOp(2'd0, 32'hFFFFFFFF, 2'd0, 0, got);
        runOp(2'd1, 32'h34333231, 2'd3, 0, got);
        runOp(2'd1, 32'h38373635, 2'd3, 5, got);
        runOp(2'd1, 32'hAABBCC39, 2'd0, 0, got);
        runOp(2'd2, 32'h0, 2'd0, 0, got);
        checkOutput("check_final", got, 32'hCBF43926);
        runOp(2'd3, 32'h0, 2'd0, 0, got);
        checkOutput("check_read", got, 32'h340BC6D9);
        runOp(2'd2, 32'h0, 2'd0, 2, got);
        checkOutput("check_final2", got, 32'hCBF43926);

        // Reset in the middle of a 4-byte update aborts it.
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_data  = $urandom;
        req_len   = 2'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("midreset_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("midreset_busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;
        rst     = 1'b1;
        ref_crc = 32'hFFFFFFFF;
        @(posedge clk); #1;
        checkOutput("midreset_ready", {31'h0, req_ready}, 32'h1);
        runOp(2'd3, 32'h0, 2'd0, 0, got);
        checkOutput("midreset_read", got, 32'hFFFFFFFF);

        // Random mix of operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            op = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) op = 2'd1;
            runOp(op, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
